// File: rtl/fir_pkg.sv
// Shared definitions for the fir block and its coefficient controller.
// Default sizes, controller state encoding and a counter-width helper.
package fir_pkg;

    localparam int BITWIDTH_DEF = 16;
    localparam int N_DEF        = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// N x BITWIDTH coefficient register bank.
// Single-word write port, bulk copy-in (wins over the write port), flat output.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF,
    parameter int N        = N_DEF,
    parameter int AW       = clog2(N)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [BITWIDTH-1:0]   data,
    input  logic                  copy_en,
    input  logic [BITWIDTH*N-1:0] copy_data,
    output logic [BITWIDTH*N-1:0] flat
);

    logic [BITWIDTH-1:0] mem [N];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (copy_en) begin
            for (int i = 0; i < N; i++)
                mem[i] <= copy_data[BITWIDTH*i +: BITWIDTH];
        end else if (we) begin
            mem[addr] <= data;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign flat[BITWIDTH*g +: BITWIDTH] = mem[g];
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient bank controller: streams a shadow bank, then swaps it into
// the active bank only while the fir sample enable is low.
module fir_coef_ctrl
    import fir_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF,
    parameter int N        = N_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_start,
    input  logic                  coef_valid,
    input  logic [BITWIDTH-1:0]   coef_data,
    input  logic                  coef_last,
    output logic                  coef_ready,
    input  logic                  fir_enable,
    output logic [BITWIDTH*N-1:0] coeffs,
    output logic                  busy,
    output logic                  swap_done,
    output logic                  load_err
);

    localparam int AW = clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     count_q, count_d;
    logic              accept;
    logic              swap;
    logic              done_d;
    logic              err_d;
    logic [BITWIDTH*N-1:0] shadow_flat;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            swap_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            swap_done <= done_d;
            load_err  <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        coef_ready = 1'b0;
        accept     = 1'b0;
        swap       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                coef_ready = !load_start;
                accept     = coef_valid && !load_start;
                if (load_start) begin
                    count_d = '0;
                end else if (accept) begin
                    count_d = count_q + AW'(1);
                    // A bank is framed correctly only when last and index N-1 coincide
                    if (coef_last && count_q == LAST_IDX) begin
                        state_d = PEND;
                    end else if (coef_last || count_q == LAST_IDX) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            PEND: begin
                if (load_start) begin
                    state_d = LOAD;
                    count_d = '0;
                end else if (!fir_enable) begin
                    swap    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    fir_coef_bank #(
        .BITWIDTH (BITWIDTH),
        .N        (N),
        .AW       (AW)
    ) u_shadow (
        .clk       (clk),
        .resetn    (resetn),
        .we        (accept),
        .addr      (count_q),
        .data      (coef_data),
        .copy_en   (1'b0),
        .copy_data ('0),
        .flat      (shadow_flat)
    );

    fir_coef_bank #(
        .BITWIDTH (BITWIDTH),
        .N        (N),
        .AW       (AW)
    ) u_active (
        .clk       (clk),
        .resetn    (resetn),
        .we        (1'b0),
        .addr      ('0),
        .data      ('0),
        .copy_en   (swap),
        .copy_data (shadow_flat),
        .flat      (coeffs)
    );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Scoreboard bench for fir_coef_ctrl: the driver predicts swap/error events
// from the bank framing rules, a monitor pops and compares them.
module tb_fir_coef_ctrl;

    localparam int BW = 16;
    localparam int N  = 16;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              load_start = 1'b0;
    logic              coef_valid = 1'b0;
    logic [BW-1:0]     coef_data = '0;
    logic              coef_last = 1'b0;
    logic              coef_ready;
    logic              fir_enable = 1'b0;
    logic [BW*N-1:0]   coeffs;
    logic              busy;
    logic              swap_done;
    logic              load_err;

    fir_coef_ctrl #(.BITWIDTH(BW), .N(N)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load_start (load_start),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_last  (coef_last),
        .coef_ready (coef_ready),
        .fir_enable (fir_enable),
        .coeffs     (coeffs),
        .busy       (busy),
        .swap_done  (swap_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int hs_cnt = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (resetn && coef_valid && coef_ready) hs_cnt <= hs_cnt + 1;

    typedef struct {
        bit            is_err;
        int            cyc;
        logic [BW*N-1:0] bank;
    } exp_t;

    exp_t            sb[$];
    logic [BW*N-1:0] model_active = '0;
    logic [BW-1:0]   wbuf[N];

    task automatic chk(input string name, input logic [BW*N-1:0] act,
                       input logic [BW*N-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [BW*N-1:0] flat_w();
        logic [BW*N-1:0] f;
        for (int i = 0; i < N; i++) f[BW*i +: BW] = wbuf[i];
        return f;
    endfunction

    // Monitor: every swap_done / load_err pulse must match the queue head
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (swap_done || load_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {swap_done, load_err}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", {swap_done, load_err},
                        e.is_err ? 2'b01 : 2'b10);
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_coeffs", coeffs, e.bank);
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missing_event_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic start_pulse();
        nxt();
        load_start = 1'b1;
        coef_valid = 1'b0;
        coef_last  = 1'b0;
        nxt();
        load_start = 1'b0;
    endtask

    task automatic send_words(input int len, input int last_pos,
                              input bit gaps, input bit expect_evt,
                              input int hold);
        exp_t e;
        int   t;
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    nxt();
                    coef_valid = 1'b0;
                    coef_data  = BW'($urandom);
                    coef_last  = 1'b0;
                end
            end
            nxt();
            coef_valid = 1'b1;
            coef_data  = wbuf[i];
            coef_last  = (i == last_pos);
            for (int k = 0; ; k++) begin
                #3;
                t = cyc;
                if (coef_ready) break;
                if (k >= 50) begin
                    chk("ready_timeout", coef_ready, 1);
                    break;
                end
                nxt();
            end
        end
        if (expect_evt) begin
            e.is_err = !(len == N && last_pos == N - 1);
            e.cyc    = e.is_err ? t + 1 : t + hold + 2;
            e.bank   = e.is_err ? model_active : flat_w();
            sb.push_back(e);
            if (!e.is_err) model_active = flat_w();
        end
        nxt();
        coef_valid = 1'b0;
        coef_last  = 1'b0;
    endtask

    task automatic do_load(input int len, input int last_pos,
                           input bit gaps, input int hold, input bit start);
        logic [BW*N-1:0] old;
        int              hs0;
        old = model_active;
        if (start) start_pulse();
        hs0 = hs_cnt;
        send_words(len, last_pos, gaps, 1'b1, hold);
        if (hold > 0) begin
            fir_enable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                chk("hold_coeffs", coeffs, old);
                chk("hold_busy", busy, 1);
                nxt();
            end
        end
        fir_enable = 1'b0;
        repeat (3) nxt();
        chk("handshakes", hs_cnt - hs0, len);
        chk("idle_busy", busy, 0);
        chk("idle_ready", coef_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_coeffs", coeffs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", coef_ready, 0);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_load_err", load_err, 0);
        #2 resetn = 1'b1;
        repeat (2) nxt();

        for (int i = 0; i < N; i++) wbuf[i] = BW'(i + 1);
        do_load(N, N - 1, 1'b0, 0, 1'b1);
        for (int i = 0; i < N; i++)
            chk("tap_ramp", coeffs[BW*i +: BW], BW'(i + 1));

        for (int i = 0; i < N; i++) wbuf[i] = BW'(3 * i + 100);
        do_load(N, N - 1, 1'b0, 10, 1'b1);

        for (int i = 0; i < N; i++) wbuf[i] = BW'($urandom);
        do_load(5, 4, 1'b0, 0, 1'b1);
        do_load(N, -1, 1'b0, 0, 1'b1);

        for (int i = 0; i < N; i++) wbuf[i] = BW'(16'h5A00 + i);
        start_pulse();
        send_words(7, -1, 1'b0, 1'b0, 0);
        for (int i = 0; i < N; i++) wbuf[i] = '1;
        do_load(N, N - 1, 1'b0, 0, 1'b1);
        for (int i = 0; i < N; i++)
            chk("tap_minus1", coeffs[BW*i +: BW], {BW{1'b1}});

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) wbuf[i] = BW'($urandom);
            do_load(N, N - 1, 1'b1, $urandom_range(0, 4), 1'b1);
        end

        start_pulse();
        for (int i = 0; i < N; i++) wbuf[i] = BW'($urandom);
        send_words(5, -1, 1'b0, 1'b0, 0);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midload_rst_coeffs", coeffs, 0);
        chk("midload_rst_busy", busy, 0);
        chk("midload_rst_ready", coef_ready, 0);
        chk("midload_rst_swap_done", swap_done, 0);
        chk("midload_rst_load_err", load_err, 0);
        sb.delete();
        model_active = '0;
        @(negedge clk);
        #2 resetn = 1'b1;

        for (int i = 0; i < N; i++) wbuf[i] = BW'($urandom);
        do_load(N, N - 1, 1'b1, 2, 1'b1);

        repeat (4) nxt();
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
Coefficient bank controller for the fir block: accepts a serial coefficient stream over a valid/ready handshake into a shadow bank. It swaps the shadow bank into the active bank only on a cycle where the FIR sample enable is low, so taps never change mid-sample. The active bank drives the FIR coefficient array as a flat bus. Sits between the host/MyHDL coefficient source and the fir instance.

Parameters:
BITWIDTH, 16, coefficient width (signed, same format as fir coefficients)
N, 16, number of taps / coefficients per bank

Ports:
clk  in  1  system clock, all logic rising-edge
resetn  in  1  asynchronous active-low reset
load_start  in  1  one-cycle pulse: begin (or restart) loading a shadow bank
coef_valid  in  1  coef_data valid
coef_data  in  BITWIDTH  signed coefficient word; first word = tap 0
coef_last  in  1  marks final word of a bank; must coincide with word N-1
coef_ready  out  1  controller accepts a word this cycle
fir_enable  in  1  same enable that drives fir; swap only when low
coeffs  out  BITWIDTH*N  active bank, tap i at [BITWIDTH*(i+1)-1 : BITWIDTH*i]
busy  out  1  state != IDLE
swap_done  out  1  one-cycle pulse, coeffs updated this cycle
load_err  out  1  one-cycle pulse, framing error, load aborted

Behaviour:
- Reset (resetn low, async): state IDLE, count 0, shadow and active banks all 0, coeffs 0, coef_ready 0, busy 0, swap_done 0, load_err 0.
- State IDLE: coef_ready 0. load_start -> LOAD, count <= 0.
- State LOAD: coef_ready = 1 except in the cycle where load_start is high.
  - On accept (coef_valid & coef_ready), shadow[count] <= coef_data and count++.
  - If coef_last is accepted with count == N-1, go to PEND.
  - If coef_last is accepted with count < N-1, pulse load_err next cycle and go to IDLE. The same applies if word N-1 is accepted without coef_last. The active bank is untouched; the shadow contents are don't-care.
- State PEND: coef_ready 0.
  - In the first cycle with fir_enable == 0 (including the cycle of entry), active <= shadow, swap_done pulses with the new coeffs the following cycle, then go to IDLE.
  - If fir_enable stays high, wait indefinitely.
- load_start in LOAD or PEND: restart. count <= 0, go to LOAD, and discard any pending swap. load_start outranks both a handshake word and a swap eligible in the same cycle.
- Latency: last word accepted in cycle t -> PEND at t+1 -> earliest swap at t+1 (fir_enable low). coeffs and swap_done change at t+2.
- coeffs is a registered output from the active bank only. It never shows partially loaded shadow data.
- Counter is clog2(N) bits wide, with no wrap: reaching N-1 always exits LOAD.
- coef_valid while coef_ready is low is ignored; the source holds the word.
- Reset mid-load or mid-pending: full clear per the reset line above, and the active bank returns to zeros.

Decomposition:
- Shared package (fir_pkg): BITWIDTH/N defaults, state encoding constants (IDLE/LOAD/PEND), and a clog2 function for the counter width. These are shared with fir and the dut_* benches.
- One natural sub-module: fir_coef_bank. It holds an N×BITWIDTH register array with a write port (we, addr, data), a bulk copy-in, and a flat output.
- The controller FSM lives in fir_coef_ctrl; fir_coef_ctrl instantiates two fir_coef_bank blocks (shadow and active).

Test Plan:
- Reset then idle, with N=16 -> coeffs == 0, busy 0, coef_ready 0. Assert resetn low mid-LOAD -> all outputs return to 0 asynchronously.
- load_start, stream 1..16 with coef_last on the 16th, fir_enable 0 -> swap_done 2 cycles after the last accept, and coeffs tap i == i+1. Feeding fir an impulse of 1 gives outputs 1,2,...,16.
- Same load with fir_enable held high for 10 cycles after the last word -> no swap while high, and coeffs stays at the previous bank. swap_done comes one cycle after the first low cycle.
- coef_last asserted on word 5 -> load_err pulse, state IDLE, coeffs unchanged. Also check word 16 without coef_last -> load_err.
- load_start reasserted after 7 words, then a full load of all -1 -> coeffs tap i == -1 for all i, with no trace of the first partial stream.
- Random coef_valid gaps (about 50% duty) during a load of 16 -> every word is captured exactly once and in order. The number of cycles with coef_valid & coef_ready equals exactly 16.
